// File: rtl/awgn_sched.sv
// awgn_sched: owns the URNG seeds, flushes the noise pipeline after start and
// time-shares the Box-Muller generator among requesters by round-robin.
module awgn_sched #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int AWGN_LAT = 4,
  parameter int WARMUP   = 16
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            seed_wr_i,
  input  logic [2:0]      seed_sel_i,
  input  logic [31:0]     seed_data_i,
  output logic            seed_err_o,
  input  logic            start_i,
  input  logic            stop_i,
  output logic [31:0]     s0_o,
  output logic [31:0]     s1_o,
  output logic [31:0]     s2_o,
  output logic [31:0]     s3_o,
  output logic [31:0]     s4_o,
  output logic [31:0]     s5_o,
  output logic            taus_ce_o,
  input  logic [W-1:0]    awgn_in_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [W-1:0]    sample_out_o,
  output logic            sample_valid_o,
  output logic            busy_o
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = 9;
  localparam int TW = AWGN_LAT * IW;
  typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, win;
  logic [AWGN_LAT-1:0] tv_q, tv_d;
  logic [TW-1:0] ti_q, ti_d;
  logic [IW-1:0] head;
  logic valid_q, err_q, issue, seed_ok;
  logic [NREQ-1:0] gnt_q;
  logic [W-1:0] sample_q;
  logic [31:0] seed_q [6];
  logic [31:0] seed_min;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v >= NREQ ? v - NREQ : v);
  endfunction
  assign issue = state_q == RUN && |req_i;
  assign head  = ti_q[TW-1 -: IW];
  // Descending scan so the candidate closest above the last winner is assigned last and wins.
  always_comb begin
    win = ptr_q;
    for (int k = NREQ; k >= 1; k--)
      if (req_i[wrap(int'(ptr_q) + k)]) win = wrap(int'(ptr_q) + k);
  end
  assign ptr_d = issue ? win : ptr_q;
  assign tv_d  = AWGN_LAT'({tv_q, issue});
  assign ti_d  = TW'({ti_q, issue ? win : IW'(0)});
  assign seed_min = (seed_sel_i == 3'd0 || seed_sel_i == 3'd3) ? 32'd2 :
                    (seed_sel_i == 3'd1 || seed_sel_i == 3'd4) ? 32'd8 : 32'd16;
  assign seed_ok = state_q == IDLE && seed_sel_i <= 3'd5 && seed_data_i >= seed_min;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (start_i && !stop_i) begin
        state_d = WARM;
        cnt_d = CW'(AWGN_LAT + WARMUP - 1);
      end
      WARM: begin
        cnt_d = cnt_q - CW'(1);
        state_d = stop_i ? DRAIN : cnt_q == '0 ? RUN : WARM;
      end
      RUN: state_d = stop_i ? DRAIN : RUN;
      DRAIN: state_d = |tv_q ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      tv_q     <= '0;
      ti_q     <= '0;
      valid_q  <= 1'b0;
      gnt_q    <= '0;
      sample_q <= '0;
      err_q    <= 1'b0;
      seed_q[0] <= 32'd12345;
      seed_q[1] <= 32'd67890;
      seed_q[2] <= 32'd13579;
      seed_q[3] <= 32'd24680;
      seed_q[4] <= 32'd11111;
      seed_q[5] <= 32'd99999;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      tv_q     <= tv_d;
      ti_q     <= ti_d;
      valid_q  <= tv_q[AWGN_LAT-1];
      gnt_q    <= tv_q[AWGN_LAT-1] ? NREQ'(1) << head : '0;
      sample_q <= awgn_in_i;
      err_q    <= seed_wr_i && !seed_ok;
      if (seed_wr_i && seed_ok) seed_q[seed_sel_i] <= seed_data_i;
    end
  end
  assign taus_ce_o      = state_q == WARM || issue;
  assign busy_o         = state_q != IDLE;
  assign sample_valid_o = valid_q;
  assign gnt_o          = gnt_q;
  assign sample_out_o   = sample_q;
  assign seed_err_o     = err_q;
  assign s0_o = seed_q[0];
  assign s1_o = seed_q[1];
  assign s2_o = seed_q[2];
  assign s3_o = seed_q[3];
  assign s4_o = seed_q[4];
  assign s5_o = seed_q[5];
endmodule

// File: tb/tb_awgn_sched.sv
// tb_awgn_sched: directed stimulus, checked every cycle against a transaction-level
// model of the scheduler, plus literal expectations for the key scenarios.
module tb_awgn_sched;
  localparam int NREQ = 4, W = 16, L = 4, WU = 16;
  logic clk = 0, rst_n = 0, seed_wr = 0, start = 0, stop = 0;
  logic [2:0] seed_sel = 0;
  logic [31:0] seed_data = 0;
  logic [W-1:0] awgn = 16'hACE1;
  logic [NREQ-1:0] req = 0;
  logic seed_err, taus_ce, sample_valid, busy;
  logic [31:0] s0, s1, s2, s3, s4, s5;
  logic [NREQ-1:0] gnt;
  logic [W-1:0] sample_out;

  awgn_sched #(.NREQ(NREQ), .W(W), .AWGN_LAT(L), .WARMUP(WU)) dut (
    .clk_i(clk), .reset_ni(rst_n), .seed_wr_i(seed_wr), .seed_sel_i(seed_sel),
    .seed_data_i(seed_data), .seed_err_o(seed_err), .start_i(start), .stop_i(stop),
    .s0_o(s0), .s1_o(s1), .s2_o(s2), .s3_o(s3), .s4_o(s4), .s5_o(s5),
    .taus_ce_o(taus_ce), .awgn_in_i(awgn), .req_i(req), .gnt_o(gnt),
    .sample_out_o(sample_out), .sample_valid_o(sample_valid), .busy_o(busy));

  always #5 clk = ~clk;
  always @(negedge clk) awgn <= {awgn[14:0], awgn[15] ^ awgn[13] ^ awgn[12] ^ awgn[10]};

  typedef enum {M_IDLE, M_WARM, M_RUN, M_DRAIN} mode_t;
  mode_t mode = M_IDLE;
  int last = NREQ - 1, warm_left = 0, en = 0;
  int due_q[$];
  int idx_q[$];
  logic [31:0] m_seed [6];
  logic e_valid = 0, e_err = 0;
  logic [NREQ-1:0] e_gnt = 0;
  logic [W-1:0] e_sample = 0;
  int tests = 0, fails = 0, ncyc = 0;
  logic [NREQ-1:0] obs[$];
  int obs_cyc[$];
  int mins[3] = '{2, 8, 16};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, ncyc);
    end
  endtask

  // Advances the model by one clock edge using the inputs the DUT is about to sample.
  task automatic model_step();
    bit empty;
    int w;
    en++;
    if (!rst_n) begin
      mode = M_IDLE; last = NREQ - 1; warm_left = 0;
      due_q.delete(); idx_q.delete();
      e_valid = 0; e_gnt = 0; e_sample = 0; e_err = 0;
      m_seed = '{32'd12345, 32'd67890, 32'd13579, 32'd24680, 32'd11111, 32'd99999};
    end else begin
      empty = due_q.size() == 0;
      e_valid = 0;
      e_gnt = 0;
      if (due_q.size() != 0 && due_q[0] == en) begin
        e_valid = 1;
        e_gnt = NREQ'(1) << idx_q[0];
        void'(due_q.pop_front());
        void'(idx_q.pop_front());
      end
      if (mode == M_RUN && req != 0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(last + k) % NREQ]) w = (last + k) % NREQ;
        due_q.push_back(en + L);
        idx_q.push_back(w);
        last = w;
      end
      e_sample = awgn;
      e_err = 0;
      if (seed_wr) begin
        if (mode == M_IDLE && seed_sel <= 5 && seed_data >= 32'(mins[seed_sel % 3]))
          m_seed[seed_sel] = seed_data;
        else
          e_err = 1;
      end
      case (mode)
        M_IDLE: if (start && !stop) begin mode = M_WARM; warm_left = L + WU; end
        M_WARM: begin
          warm_left--;
          if (stop) mode = M_DRAIN;
          else if (warm_left == 0) mode = M_RUN;
        end
        M_RUN: if (stop) mode = M_DRAIN;
        default: if (empty) mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare();
    check("busy", busy, mode != M_IDLE);
    check("taus_ce", taus_ce, mode == M_WARM || (mode == M_RUN && req != 0));
    check("sample_valid", sample_valid, e_valid);
    check("gnt", gnt, e_gnt);
    check("sample_out", sample_out, e_sample);
    check("seed_err", seed_err, e_err);
    check("s0", s0, m_seed[0]);
    check("s1", s1, m_seed[1]);
    check("s2", s2, m_seed[2]);
    check("s3", s3, m_seed[3]);
    check("s4", s4, m_seed[4]);
    check("s5", s5, m_seed[5]);
  endtask

  task automatic tick();
    #2;
    model_step();
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    compare();
    if (sample_valid) begin
      obs.push_back(gnt);
      obs_cyc.push_back(ncyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, t0;
    logic [NREQ-1:0] g_all [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    logic [NREQ-1:0] g_mix [8] = '{1, 4, 1, 4, 1, 1, 1, 1};
    logic [NREQ-1:0] g_stp [4] = '{2, 4, 8, 1};
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
    check("rst_s1", s1, 32'd67890);
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ce", taus_ce, 0);
    seed_wr = 1; seed_sel = 1; seed_data = 5; tick(); seed_wr = 0;
    check("low_s1_err", seed_err, 1);
    check("low_s1_keep", s1, 32'd67890);
    seed_wr = 1; seed_data = 100; tick(); seed_wr = 0;
    check("ok_s1_err", seed_err, 0);
    check("ok_s1", s1, 32'd100);
    seed_wr = 1; seed_sel = 2; seed_data = 15; tick();
    check("min_s2_err", seed_err, 1);
    seed_data = 16; tick(); seed_wr = 0;
    check("min_s2", s2, 32'd16);
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("start_stop_idle", busy, 0);
    start = 1; tick(); start = 0;
    k = 0; obs.delete();
    repeat (30) begin
      if (taus_ce) k++;
      tick();
    end
    check("warm_ce_cycles", k, 20);
    check("warm_no_valid", obs.size(), 0);
    obs.delete(); obs_cyc.delete();
    req = 4'b1111; t0 = ncyc;
    seed_wr = 1; seed_sel = 0; seed_data = 500; tick(); seed_wr = 0;
    check("run_wr_err", seed_err, 1);
    check("run_wr_s0", s0, 32'd12345);
    repeat (7) tick();
    req = 0; repeat (8) tick();
    check("rr_count", obs.size(), 8);
    for (int i = 0; i < obs.size() && i < 8; i++) check("rr_all_gnt", obs[i], g_all[i]);
    if (obs_cyc.size() > 0) check("latency", obs_cyc[0] - t0, 5);
    obs.delete();
    req = 4'b0001; tick();
    req = 4'b0101; repeat (4) tick();
    req = 4'b0001; repeat (3) tick();
    req = 0; repeat (6) tick();
    check("rr_mix_count", obs.size(), 8);
    for (int i = 0; i < obs.size() && i < 8; i++) check("rr_mix_gnt", obs[i], g_mix[i]);
    obs.delete();
    req = 4'b1111; repeat (3) tick();
    stop = 1; tick(); stop = 0; req = 0;
    k = 0;
    while (busy && k < 10) begin tick(); k++; end
    check("drain_cycles", k, 5);
    check("drain_count", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) check("drain_gnt", obs[i], g_stp[i]);
    seed_wr = 1; seed_sel = 7; seed_data = 1000; tick(); seed_wr = 0;
    check("bad_sel_err", seed_err, 1);
    seed_wr = 1; seed_sel = 0; seed_data = 777; start = 1; tick(); seed_wr = 0; start = 0;
    check("start_seed_s0", s0, 32'd777);
    check("start_busy", busy, 1);
    repeat (20) tick();
    req = 4'b1111; repeat (3) tick();
    rst_n = 0; tick();
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s0", s0, 32'd12345);
    check("mid_rst_s1", s1, 32'd67890);
    rst_n = 1; req = 0; obs.delete();
    repeat (8) tick();
    check("no_stale_gnt", obs.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/awgn_sched.md
# awgn_sched

Sequencing and arbitration controller for the shared Gaussian-noise datapath: two Tausworthe URNGs (taus) feeding one Box-Muller generator (awgn2). It owns the six URNG seed registers, runs a warm-up flush after seeding, and time-shares the generator among up to NREQ requesters, returning each sample tagged with its requester. It sits between the seed/config bus and the channel-model consumers.

## Interface

- NREQ, 4: number of requesters, 2..8.
- W, 16: AWGN sample width.
- AWGN_LAT, 4: cycles from taus_ce issue to the matching awgn_in sample, 1..15.
- WARMUP, 16: samples discarded after start, 1..255.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- seed_wr  in  1  write seed_data into seed register seed_sel.
- seed_sel  in  3  seed index 0..5; 6 and 7 are invalid.
- seed_data  in  32  seed value.
- seed_err  out  1  one-cycle pulse on a rejected seed write.
- start  in  1  begin warm-up, then service requests.
- stop  in  1  stop issuing, drain, return to IDLE.
- s0..s5  out  32 each  seed registers; s0..s2 drive URNG1, s3..s5 drive URNG2.
- taus_ce  out  1  clock enable to both taus instances.
- awgn_in  in  W  sample from awgn2; awgn2 is free-running on clk.
- req  in  NREQ  level requests, one bit per requester.
- gnt  out  NREQ  one-hot requester tag qualified by sample_valid.
- sample_out  out  W  delivered sample.
- sample_valid  out  1  sample_out and gnt are valid this cycle.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, WARM, RUN, DRAIN.
- **Seed writes**
  - Accepted only in IDLE.
  - Rejected when seed_sel > 5.
  - Rejected when the value is below the Tausworthe minimum: s0/s3 ≥ 2, s1/s4 ≥ 8, s2/s5 ≥ 16.
  - A rejected write leaves the register unchanged and pulses seed_err the next cycle. Writes outside IDLE also pulse seed_err.
- **IDLE -> WARM** on start.
  - If seed_wr and start occur in the same cycle, the write lands and WARM uses the new seed.
- **WARM**
  - taus_ce is high every cycle.
  - A counter issues AWGN_LAT+WARMUP cycles; outputs are discarded.
  - When the counter expires, go to RUN.
- **RUN**
  - Each cycle with any req bit high: assert taus_ce, pick one requester by round-robin, and push {valid, index} into an AWGN_LAT-deep tag shift register.
  - Round-robin search starts at the bit above the last winner. The pointer advances only on a grant.
  - With no req: taus_ce is low and a {0, x} tag is pushed.
- **Tag shift register**
  - Shifts every clk.
  - At the head: sample_valid = tag valid, gnt = onehot(index) when valid, else 0; sample_out = awgn_in, registered.
- **stop**
  - stop in WARM or RUN -> DRAIN.
  - In DRAIN: taus_ce is low and empty tags are pushed. When the tag pipeline holds no valid entry, go to IDLE.
  - If start and stop occur in the same cycle, stop wins. start in DRAIN is ignored.
- **Reset** (any state, synchronous)
  - State -> IDLE; the tag pipeline and warm counter clear.
  - Round-robin pointer -> requester NREQ-1, so requester 0 is first.
  - Seeds -> s0=12345, s1=67890, s2=13579, s3=24680, s4=11111, s5=99999 (decimal).

## Timing

- **Reset values:** taus_ce 0, sample_valid 0, gnt 0, sample_out 0, seed_err 0, busy 0, seeds as above.
- **Start:** start sampled in cycle t -> busy and taus_ce high at t+1. The first RUN issue is no earlier than t+1+AWGN_LAT+WARMUP.
- **Sample latency:** an issue in cycle t -> sample_valid with the matching gnt at t+AWGN_LAT+1. The +1 is the output register.
- **Throughput:** one sample per cycle. No back-pressure; consumers must accept when their gnt bit is set.
- **Round-robin wrap:** after index NREQ-1, the search continues at 0.
- **Single requester:** a lone requester holding req is granted every cycle.
- **Drain:** DRAIN lasts at most AWGN_LAT+1 cycles. busy falls the cycle IDLE is entered.

## Test plan

- Reset, then seed_wr sel=1 data=5 -> seed_err pulses; s1 stays 67890. Then sel=1 data=100 -> s1=100, no error.
- start, req=4'b0000 -> taus_ce high for exactly AWGN_LAT+WARMUP=20 cycles, then low; no sample_valid.
- RUN with req=4'b1111 held for 8 issues -> gnt sequence 0,1,2,3,0,1,2,3. Each sample_valid appears 5 cycles after its issue.
- req=4'b0101 with the pointer at 0 -> grants alternate 2,0,2,0. Dropping req[2] mid-stream gives 0 every cycle.
- stop in RUN with 4 tags in flight -> all 4 samples delivered. busy falls within 5 cycles; seed_wr sel=7 -> seed_err.
- reset low mid-RUN with tags in flight -> next cycle sample_valid 0, busy 0, seeds back to defaults, no stale gnt afterwards.
